// File: rtl/frv_masked_shfrot_iter.sv
// Iterative two-share masked shifter/rotator.
// One barrel stage per cycle, shares never recombined.
module frv_masked_shfrot_iter #(
  parameter int BIT_WIDTH = 32,
  parameter bit REFRESH   = 1'b1,
  localparam int SHAMT_W  = $clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 slli,
  input  logic                 srli,
  input  logic                 srai,
  input  logic                 rori,
  input  logic                 roli,
  input  logic [SHAMT_W-1:0]   shamt,
  input  logic [BIT_WIDTH-1:0] s0,
  input  logic [BIT_WIDTH-1:0] s1,
  input  logic [BIT_WIDTH-1:0] rp0,
  output logic [BIT_WIDTH-1:0] r0,
  output logic [BIT_WIDTH-1:0] r1,
  output logic                 ready
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROR,
    OP_ROL
  } op_t;

  localparam logic [SHAMT_W-1:0] LAST =
    SHAMT_W'(SHAMT_W - 1);

  state_t               r_state;
  state_t               w_next;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [SHAMT_W-1:0]   r_shamt;
  op_t                  r_op;
  logic [BIT_WIDTH-1:0] r_w0;
  logic [BIT_WIDTH-1:0] r_w1;
  logic [BIT_WIDTH-1:0] r_r0;
  logic [BIT_WIDTH-1:0] r_r1;

  logic [4:0]           w_ops;
  logic                 w_start;
  op_t                  w_op;
  logic                 w_last;
  logic                 w_en;
  logic [BIT_WIDTH-1:0] w_mask;
  logic [BIT_WIDTH-1:0] w_n0;
  logic [BIT_WIDTH-1:0] w_n1;

  // One barrel stage on a single share: move by 2^k when en is set.
  // SRA replicates the share's own MSB; XOR of fills is the true sign.
  function automatic logic [BIT_WIDTH-1:0] f_stage(
    input logic [BIT_WIDTH-1:0] x,
    input op_t                  op,
    input logic [SHAMT_W-1:0]   k,
    input logic                 en
  );
    logic [2*BIT_WIDTH-1:0] d;
    logic [BIT_WIDTH-1:0]   y;
    logic [SHAMT_W-1:0]     amt;
    amt = SHAMT_W'(1) << k;
    d   = {x, x};
    y   = x;
    if (en) begin
      case (op)
        OP_SLL: y = x << amt;
        OP_SRL: y = x >> amt;
        OP_SRA: y = $unsigned($signed(x) >>> amt);
        OP_ROR: begin
          d = d >> amt;
          y = d[BIT_WIDTH-1:0];
        end
        OP_ROL: begin
          d = d << amt;
          y = d[2*BIT_WIDTH-1:BIT_WIDTH];
        end
        default: y = x;
      endcase
    end
    return y;
  endfunction

  assign w_ops   = {roli, rori, srai, srli, slli};
  assign w_start = ena && $onehot(w_ops);
  assign w_last  = (r_cnt == LAST);
  assign w_en    = r_shamt[r_cnt];
  assign w_mask  = REFRESH ? rp0 : '0;
  assign w_n0    = f_stage(r_w0, r_op, r_cnt, w_en) ^ w_mask;
  assign w_n1    = f_stage(r_w1, r_op, r_cnt, w_en) ^ w_mask;

  // Encode the one-hot op select (only used when exactly one is set).
  always_comb begin
    w_op = OP_SLL;
    if (srli)      w_op = OP_SRL;
    else if (srai) w_op = OP_SRA;
    else if (rori) w_op = OP_ROR;
    else if (roli) w_op = OP_ROL;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands, run stages, load result shares.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shamt <= '0;
      r_op    <= OP_SLL;
      r_w0    <= '0;
      r_w1    <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_w0    <= s0;
            r_w1    <= s1;
            r_shamt <= shamt;
            r_op    <= w_op;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_w0  <= w_n0;
          r_w1  <= w_n1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_r0 <= w_n0;
            r_r1 <= w_n1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r0    = r_r0;
  assign r1    = r_r1;
  assign ready = (r_state == DONE);

endmodule

// File: tb/tb_frv_masked_shfrot_iter.sv
// Self-checking bench for frv_masked_shfrot_iter.
// Random and directed ops against an unmasked shift model.
module tb_frv_masked_shfrot_iter;

  localparam int W  = 32;
  localparam int SW = 5;

  localparam logic [4:0] SLL = 5'b00001;
  localparam logic [4:0] SRL = 5'b00010;
  localparam logic [4:0] SRA = 5'b00100;
  localparam logic [4:0] ROR = 5'b01000;
  localparam logic [4:0] ROL = 5'b10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [4:0]    ops;
  logic [SW-1:0] shamt;
  logic [W-1:0]  s0, s1, rp0;
  logic [W-1:0]  r0, r1;
  logic          ready;
  logic          rp_rand;

  int nchk = 0;
  int nerr = 0;

  frv_masked_shfrot_iter #(.BIT_WIDTH(W), .REFRESH(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .slli  (ops[0]),
    .srli  (ops[1]),
    .srai  (ops[2]),
    .rori  (ops[3]),
    .roli  (ops[4]),
    .shamt (shamt),
    .s0    (s0),
    .s1    (s1),
    .rp0   (rp0),
    .r0    (r0),
    .r1    (r1),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // fresh randomness each cycle, or zero for exact share checks
  always @(negedge clk) rp0 <= rp_rand ? W'($urandom) : '0;

  function automatic logic [W-1:0] model(
    input logic [4:0] op, input int n, input logic [W-1:0] x);
    logic [2*W-1:0] d;
    logic [W-1:0]   y;
    d = {x, x};
    y = x;
    if (op == SLL) y = x << n;
    else if (op == SRL) y = x >> n;
    else if (op == SRA) y = $unsigned($signed(x) >>> n);
    else if (op == ROR) begin
      d = d >> n;
      y = d[W-1:0];
    end else if (op == ROL) begin
      d = d << n;
      y = d[2*W-1:W];
    end
    return y;
  endfunction

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after latch, wait for ready.
  task automatic do_op(input logic [4:0] op,
                       input logic [SW-1:0] sh,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output logic [W-1:0] x,
                       output int lat);
    @(negedge clk);
    ena = 1'b1; ops = op; shamt = sh; s0 = a; s1 = b;
    @(posedge clk);
    lat = 0;
    x = 'x;
    while (lat < 30) begin
      @(negedge clk);
      ena = 1'b0;
      ops = 5'($urandom);
      shamt = SW'($urandom);
      s0 = W'($urandom);
      s1 = W'($urandom);
      lat++;
      if (ready) begin
        x = r0 ^ r1;
        break;
      end
    end
  endtask

  initial begin
    logic [W-1:0] x, a, b;
    int lat, n, t1, t2, nrdy;
    rst = 1'b1; ena = 1'b0; ops = '0; shamt = '0;
    s0 = '0; s1 = '0; rp_rand = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r0", r0, '0);
    check("rst_r1", r1, '0);
    check("rst_ready", W'(ready), '0);
    rst = 1'b0;

    // directed SLL with zero randomness: exact shares
    do_op(SLL, 5'd4, 32'h0484D609, 32'h31F05663, x, lat);
    check("sll_r0", r0, 32'h484D6090);
    check("sll_r1", r1, 32'h1F056630);
    check("sll_x", x, 32'h574806A0);
    check("sll_lat", W'(lat), W'(SW + 1));

    rp_rand = 1'b1;
    do_op(SRL, 5'd4, 32'h0484D609, 32'h31F05663, x, lat);
    check("srl_x", x, 32'h03574806);
    do_op(ROR, 5'd4, 32'h0484D609, 32'h31F05663, x, lat);
    check("ror_x", x, 32'hA3574806);
    do_op(ROL, 5'd8, 32'h0484D609, 32'h31F05663, x, lat);
    check("rol_x", x, 32'h74806A35);
    do_op(SRA, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A5 ^ 32'hF0000000, x, lat);
    check("sra_neg", x, 32'hFF000000);
    do_op(SRA, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A5 ^ 32'h70000000, x, lat);
    check("sra_pos", x, 32'h07000000);

    // boundary and random shift amounts, every op
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 240; i++) begin
        logic [4:0] op;
        op = 5'(1 << o);
        n = (i < 80) ? 0 : (i < 160) ? W - 1 : int'($urandom_range(0, W - 1));
        a = W'($urandom);
        b = W'($urandom);
        do_op(op, SW'(n), a, b, x, lat);
        check($sformatf("rand_op%0d_n%0d", o, n), x, model(op, n, a ^ b));
        check($sformatf("rand_lat%0d", o), W'(lat), W'(SW + 1));
      end
    end

    // back-to-back with ena held high
    a = W'($urandom);
    b = W'($urandom);
    @(negedge clk);
    ena = 1'b1; ops = ROR; shamt = 5'd13; s0 = a; s1 = b;
    t1 = -1; t2 = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        check("b2b_x", r0 ^ r1, model(ROR, 13, a ^ b));
        if (t1 < 0) t1 = c;
        else begin
          t2 = c;
          ena = 1'b0;
          break;
        end
      end
    end
    check("b2b_gap", W'(t2 - t1), W'(SW + 2));

    // illegal request: two op selects set
    repeat (3) @(negedge clk);
    ena = 1'b1; ops = SLL | SRL; shamt = 5'd3;
    nrdy = 0;
    repeat (15) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    ena = 1'b0; ops = '0;
    check("illegal_nordy", W'(nrdy), '0);

    // reset while cnt=2
    @(negedge clk);
    ena = 1'b1; ops = SLL; shamt = 5'd1; s0 = 32'h1; s1 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_r0", r0, '0);
    check("mid_rst_r1", r1, '0);
    nrdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    check("mid_rst_nordy", W'(nrdy), '0);
    do_op(SRA, 5'd31, 32'h80000000, 32'h0, x, lat);
    check("post_rst_x", x, 32'hFFFFFFFF);
    check("post_rst_lat", W'(lat), W'(SW + 1));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
